pipeline_stage_skid: RTL



---
 rtl/pipeline_stage_skid_pkg.sv | 21 ++
 rtl/pipeline_stage_skid_sat_counter.sv | 24 ++
 rtl/pipeline_stage_skid.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipeline_stage_skid_pkg.sv
// Shared definitions for the elastic stage register: state encoding and the
// bit layout of the EX/MEM control bundle.
package pipeline_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } skidState_t;

    // EX/MEM control bundle: [0] RegWrite, [2:1] MemRead, [4:3] MemWrite, [7:5] MemToRegMux
    localparam int CTRL_REGWRITE     = 0;
    localparam int CTRL_MEMREAD_LSB  = 1;
    localparam int CTRL_MEMREAD_W    = 2;
    localparam int CTRL_MEMWRITE_LSB = 3;
    localparam int CTRL_MEMWRITE_W   = 2;
    localparam int CTRL_MEMTOREG_LSB = 5;
    localparam int CTRL_MEMTOREG_W   = 3;
    localparam int EXMEM_CTRL_W      = 8;

endpackage

// File: rtl/pipeline_stage_skid_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping, so a long
// stall never makes the performance counter look small again.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Elastic inter-stage register with a 2-entry skid buffer: main entry drives
// the outputs, skid catches the one extra entry accepted while downstream stalls.
module pipeline_stage_skid
    import pipeline_stage_skid_pkg::*;
#(
    parameter int PAYLOAD_W = 136,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [PAYLOAD_W-1:0] inPayload,
    input  logic [CTRL_W-1:0]    inCtrl,
    input  logic                 inFlush,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [PAYLOAD_W-1:0] outPayload,
    output logic [CTRL_W-1:0]    outCtrl,
    output logic [CNT_W-1:0]     outStallCount,
    output logic [CNT_W-1:0]     outFlushCount
);

    skidState_t           state_q, state_d;
    logic [PAYLOAD_W-1:0] mainPayload_q, mainPayload_d;
    logic [CTRL_W-1:0]    mainCtrl_q, mainCtrl_d;
    logic [PAYLOAD_W-1:0] skidPayload_q, skidPayload_d;
    logic [CTRL_W-1:0]    skidCtrl_q, skidCtrl_d;

    logic inXfer;
    logic outXfer;
    logic stallInc;
    logic flushInc;

    // inReady depends only on state and reset, never on outReady, so the
    // ready path does not chain combinationally through the pipeline.
    assign inReady  = !Rst && (state_q != ST_FULL);
    assign outValid = (state_q != ST_EMPTY);
    assign inXfer   = inValid && inReady;
    assign outXfer  = outValid && outReady;

    always_comb begin
        state_d       = state_q;
        mainPayload_d = mainPayload_q;
        mainCtrl_d    = mainCtrl_q;
        skidPayload_d = skidPayload_q;
        skidCtrl_d    = skidCtrl_q;

        if (inFlush) begin
            // Payload may stay stale; clearing ctrl is what turns the slot into a bubble.
            state_d    = ST_EMPTY;
            mainCtrl_d = '0;
            skidCtrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (inXfer) begin
                        state_d       = ST_HALF;
                        mainPayload_d = inPayload;
                        mainCtrl_d    = inCtrl;
                    end
                end
                ST_HALF: begin
                    if (inXfer && !outXfer) begin
                        state_d       = ST_FULL;
                        skidPayload_d = inPayload;
                        skidCtrl_d    = inCtrl;
                    end else if (!inXfer && outXfer) begin
                        state_d    = ST_EMPTY;
                        mainCtrl_d = '0;
                    end else if (inXfer && outXfer) begin
                        mainPayload_d = inPayload;
                        mainCtrl_d    = inCtrl;
                    end
                end
                ST_FULL: begin
                    if (outXfer) begin
                        state_d       = ST_HALF;
                        mainPayload_d = skidPayload_q;
                        mainCtrl_d    = skidCtrl_q;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    mainCtrl_d = '0;
                    skidCtrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_EMPTY;
            mainPayload_q <= '0;
            mainCtrl_q    <= '0;
            skidPayload_q <= '0;
            skidCtrl_q    <= '0;
        end else begin
            state_q       <= state_d;
            mainPayload_q <= mainPayload_d;
            mainCtrl_q    <= mainCtrl_d;
            skidPayload_q <= skidPayload_d;
            skidCtrl_q    <= skidCtrl_d;
        end
    end

    assign outPayload = mainPayload_q;
    assign outCtrl    = mainCtrl_q;

    // A flush of an already-empty stage kills nothing and is not counted.
    assign stallInc = outValid && !outReady && !inFlush;
    assign flushInc = inFlush && outValid;

    sat_counter #(.W(CNT_W)) stallCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (stallInc),
        .count (outStallCount)
    );

    sat_counter #(.W(CNT_W)) flushCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (flushInc),
        .count (outFlushCount)
    );

endmodule
